// File: rtl/hd44780_cmd_queue.sv
// Command/data FIFO feeding hd44780_bytesender, one byte at a time.
// After each byte the LCD is given its execution time: 53 us, or 3 ms after clear/home.
module hd44780_cmd_queue #(
    parameter int DEPTH_BITS  = 4,
    parameter int DELAY_SHORT = 636,
    parameter int DELAY_LONG  = 36000,
    parameter int TIMER_BITS  = 16
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  STB_I,
    input  logic                  i_rs,
    input  logic [7:0]            i_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count,
    output logic                  idle,
    output logic                  o_stb,
    output logic                  o_rs,
    output logic [7:0]            o_data,
    input  logic                  i_busy
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   CNT_FULL   = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE    = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);
    localparam logic [TIMER_BITS-1:0] LOAD_SHORT = TIMER_BITS'(DELAY_SHORT - 1);
    localparam logic [TIMER_BITS-1:0] LOAD_LONG  = TIMER_BITS'(DELAY_LONG - 1);
    localparam logic [TIMER_BITS-1:0] TIMER_ONE  = TIMER_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAITBUSY,
        S_WAITDONE,
        S_SETTLE
    } state_t;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count_next;
    logic [8:0]            head;
    logic                  push;
    logic                  pop;

    state_t                state;
    state_t                state_next;
    logic [TIMER_BITS-1:0] timer;
    logic [TIMER_BITS-1:0] timer_next;
    logic [1:0]            wd;
    logic [1:0]            wd_next;
    logic                  long_q;
    logic                  long_next;
    logic                  stb_next;
    logic                  rs_next;
    logic [7:0]            data_next;

    // The registered full flag governs, so a pop in the same cycle never admits a write.
    assign push = STB_I && !full;
    assign head = mem[rd_ptr];

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr] <= {i_rs, i_data};
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        wd_next    = wd;
        long_next  = long_q;
        stb_next   = 1'b0;
        rs_next    = o_rs;
        data_next  = o_data;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !i_busy) begin
                    pop        = 1'b1;
                    stb_next   = 1'b1;
                    rs_next    = head[8];
                    data_next  = head[7:0];
                    long_next  = !head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_next    = 2'd2;
                state_next = S_WAITBUSY;
            end
            // Busy may never be seen if the sender is quick; the watchdog prevents a deadlock.
            S_WAITBUSY: begin
                if (i_busy || wd == 2'd0) begin
                    state_next = S_WAITDONE;
                end else begin
                    wd_next = wd - 2'd1;
                end
            end
            S_WAITDONE: begin
                if (!i_busy) begin
                    timer_next = long_q ? LOAD_LONG : LOAD_SHORT;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (timer == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer - TIMER_ONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state  <= S_IDLE;
            timer  <= '0;
            wd     <= 2'd0;
            long_q <= 1'b0;
            o_stb  <= 1'b0;
            o_rs   <= 1'b0;
            o_data <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            idle   <= 1'b1;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            wd     <= wd_next;
            long_q <= long_next;
            o_stb  <= stb_next;
            o_rs   <= rs_next;
            o_data <= data_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count  <= count_next;
            full   <= (count_next == CNT_FULL);
            empty  <= (count_next == '0);
            idle   <= (count_next == '0) && (state_next == S_IDLE);
        end
    end

endmodule
